branch_redirect_ctrl: RTL

- Sits directly downstream of the EX-stage branch-decision logic.
- Consumes the per-instruction taken/not-taken decision plus jump indication and the computed target.
- Converts each taken control transfer into a registered PC-redirect request to fetch, using a valid/ready handshake.
- Sequences the IF/ID and ID/EX flushes and the EX stall around the redirect, and keeps a redirect performance counter.

---
 rtl/branch_redirect_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// Turns taken EX-stage control transfers into a registered PC redirect to fetch,
// and sequences the IF/ID and ID/EX flushes, the EX stall, and a redirect counter.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int C_EXT        = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            branch,
  input  logic            is_jump,
  input  logic [XLEN-1:0] target,
  input  logic            redirect_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            ex_stall,
  output logic            misalign_err,
  output logic [31:0]     redirect_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t     state;
  logic [3:0] flush_cnt;
  logic       resolve;
  logic       misaligned;

  assign resolve    = ex_valid & (branch | is_jump);
  assign misaligned = (C_EXT != 0) ? target[0] : |target[1:0];

  // NOTE: every register here resets asynchronously, including redirect_pc and the
  // counter, so a reset mid-redirect leaves nothing behind for fetch to act on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if_id    <= 1'b0;
      flush_id_ex    <= 1'b0;
      ex_stall       <= 1'b0;
      misalign_err   <= 1'b0;
      redirect_count <= '0;
    end else begin
      // NOTE: state and outputs use non-blocking assignments so every branch below
      // sees the pre-edge values, regardless of statement order.
      misalign_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (resolve && !misaligned) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
            flush_if_id    <= 1'b1;
            flush_id_ex    <= 1'b1;
            ex_stall       <= 1'b1;
          end else if (resolve) begin
            misalign_err <= 1'b1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_count <= redirect_count + 32'd1;
            redirect_valid <= 1'b0;
            flush_id_ex    <= 1'b0;
            ex_stall       <= 1'b0;
            if (FLUSH_CYCLES > 0) begin
              state       <= FLUSH;
              flush_cnt   <= FLUSH_LOAD;
              flush_if_id <= 1'b1;
            end else begin
              state       <= IDLE;
              flush_if_id <= 1'b0;
            end
          end
        end
        FLUSH: begin
          // Leaving on a count of 1 keeps flush_if_id high for exactly FLUSH_CYCLES
          // cycles after the handshake cycle.
          if (flush_cnt <= 4'd1) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            flush_if_id <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush_if_id    <= 1'b0;
          flush_id_ex    <= 1'b0;
          ex_stall       <= 1'b0;
        end
      endcase
    end
  end

endmodule
